iter_mul_unit: RTL and testbench
================================

Name: iter_mul_unit

Overview:
Iterative integer multiplier execute unit that sits in the X stage beside the single-cycle ALU. It takes D__X messages and returns X__W messages using the same val/rdy protocol. It implements the RV32M multiply uops with a shift-add datapath that retires p_bits_per_cycle multiplier bits per cycle. This makes the latency/area trade-off tunable by parameter and makes the unit a true multi-cycle X variant with backpressure on both sides.

Parameters:
p_addr_bits, 32, PC width
p_data_bits, 32, operand/result width N; must be a multiple of p_bits_per_cycle
p_seq_num_bits, 5, sequence-number width
p_bits_per_cycle, 1, multiplier bits consumed per CALC cycle B; iterations K = N/B

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
D.val  in  1  request valid (D__XIntf)
D.rdy  out  1  request ready
D.pc  in  p_addr_bits  instruction PC
D.seq_num  in  p_seq_num_bits  sequence number
D.op1  in  p_data_bits  multiplicand rs1
D.op2  in  p_data_bits  multiplier rs2
D.waddr  in  5  destination register
D.uop  in  rv_uop  OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU
W.val  out  1  result valid (X__WIntf)
W.rdy  in  1  writeback ready
W.pc  out  p_addr_bits  latched PC
W.seq_num  out  p_seq_num_bits  latched seq_num
W.waddr  out  5  latched waddr
W.wdata  out  p_data_bits  result
W.wen  out  1  write enable

Behaviour:
- FSM states: IDLE, CALC, DONE. Reset (rst low, async) forces IDLE, counter=0, accumulator=0, latched fields=0.
- Reset values: W.val=0, W.wen=0, W.wdata/pc/seq_num/waddr=0. D.rdy=1 once rst is deasserted.
- Any in-flight operation is dropped on reset; no W message is produced for it.
- D.rdy=1 only in IDLE. W.val=1 only in DONE. D.rdy has no combinational dependence on W.rdy.
- IDLE: on D.val&&D.rdy, latch pc, seq_num, waddr, uop.
- Operand signedness: op1 signed for MULH/MULHSU; op2 signed for MULH only.
- Latch |op1| and |op2| as N-bit unsigned. Record neg = sign1 XOR sign2, counting only signed operands.
- Clear the 2N-bit accumulator and the counter, then go to CALC.
- CALC: each cycle, add multiplicand*(low B bits of multiplier), shifted by counter*B, into the accumulator. Shift the multiplier right by B and increment the counter.
- After the K-th CALC cycle, go to DONE. If neg, replace the accumulator with its two's-complement negation (2N bits) on that transition.
- DONE: wdata = acc[N-1:0] for OP_MUL, else acc[2N-1:N]. wen=1. All W fields stay stable while W.val && !W.rdy.
- On W.val&&W.rdy, go to IDLE. A new request is accepted no earlier than the following cycle.
- Latency: if the D handshake happens in cycle t, W.val first rises in cycle t+K+1. Throughput is one op per K+2 cycles with W.rdy=1.
- Operand edge cases:
  - Most-negative operand: the abs value is 2^(N-1), which is representable unsigned, so the result is correct.
  - Zero operands need no special-casing.
- Any uop outside the four listed is computed as OP_MUL; the bench never issues such uops.
- D fields are ignored outside IDLE.
- trace: a fixed-width string showing state, counter, and seq_num; this trace output is required.

Decomposition:
- rv_uop already supplies OP_MUL/MULH/MULHSU/MULHU in the UArch package.
- Add to the same package: the FSM state enum for this unit and a helper that maps uop to {op1_signed, op2_signed, take_high}.
- One natural sub-module: mul_step, a combinational B-bit partial-product adder (acc, multiplicand, multiplier slice, shift) that returns the new acc.

Test Plan:
- Basic, B=1: send pc=0, seq=0, op1=3, op2=4, waddr=1, OP_MUL -> recv pc=0, seq=0, waddr=1, wdata=12, wen=1.
- Signed: MULH -1×-1 -> wdata=0. OP_MUL -1×-1 -> 1. MULH 0x80000000×0x80000000 -> 0x40000000.
- Unsigned/mixed:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU op1=-1, op2=0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHSU op1=2, op2=0x80000000 -> 1.
- Latency sweep: for p_bits_per_cycle=1, 4, 8 with N=32, W.val rises exactly 33, 9, 5 cycles after the D handshake. Five back-to-back sends with seq 1..5 return in order.
- Backpressure: hold W.rdy=0 for 5 cycles in DONE -> W fields stable, D.rdy=0. Run suites with delays (3,0), (0,3) and (3,3) -> all messages match.
- Reset mid-op: assert rst in CALC cycle 3 -> W.val=0 immediately, D.rdy=1 after release, no stale result emitted. The next op (5×7, MUL) -> 35.

Source files
------------

// File: rtl/iter_mul_unit_pkg.sv
// Shared types for the iterative multiplier: uop encoding, FSM states, and
// the uop-to-signedness decode plus a hex-digit helper for the trace string.
package iter_mul_unit_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd8,
    OP_MULH   = 4'd9,
    OP_MULHSU = 4'd10,
    OP_MULHU  = 4'd11
  } rv_uop;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic op1_signed;
    logic op2_signed;
    logic take_high;
  } mul_ctrl_t;

  localparam int TRACE_CHARS = 7;

  // Anything that is not a high-half multiply behaves as OP_MUL.
  function automatic mul_ctrl_t mul_ctrl(input rv_uop uop);
    mul_ctrl_t c;
    c = '0;
    case (uop)
      OP_MULH:   c = '{op1_signed: 1'b1, op2_signed: 1'b1, take_high: 1'b1};
      OP_MULHSU: c = '{op1_signed: 1'b1, op2_signed: 1'b0, take_high: 1'b1};
      OP_MULHU:  c = '{op1_signed: 1'b0, op2_signed: 1'b0, take_high: 1'b1};
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h57 + {4'h0, v});
  endfunction

endpackage

// File: rtl/iter_mul_unit_mul_step.sv
// One shift-add iteration: adds multiplicand * B-bit multiplier slice,
// aligned to bit position cnt*B, into the 2N-bit accumulator.
module mul_step #(
  parameter int N  = 32,
  parameter int B  = 1,
  parameter int CW = 6
) (
  input  logic [2*N-1:0] acc_i,
  input  logic [N-1:0]   mcand_i,
  input  logic [B-1:0]   slice_i,
  input  logic [CW-1:0]  cnt_i,
  output logic [2*N-1:0] acc_o
);
  localparam int SW = $clog2(2 * N);

  logic [2*N-1:0] pp;
  logic [SW-1:0]  shamt;

  always_comb begin
    pp    = {{N{1'b0}}, mcand_i} * {{(2*N-B){1'b0}}, slice_i};
    shamt = SW'(cnt_i) * SW'(B);
    acc_o = acc_i + (pp << shamt);
  end

endmodule

// File: rtl/iter_mul_unit.sv
// Multi-cycle RV32M multiply execute unit: multiplies magnitudes B bits per
// cycle, then fixes the sign once at the end. val/rdy on both sides.
module iter_mul_unit
  import iter_mul_unit_pkg::*;
#(
  parameter int p_addr_bits      = 32,
  parameter int p_data_bits      = 32,
  parameter int p_seq_num_bits   = 5,
  parameter int p_bits_per_cycle = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_val,
  output logic                      d_rdy,
  input  logic [p_addr_bits-1:0]    d_pc,
  input  logic [p_seq_num_bits-1:0] d_seq_num,
  input  logic [p_data_bits-1:0]    d_op1,
  input  logic [p_data_bits-1:0]    d_op2,
  input  logic [4:0]                d_waddr,
  input  rv_uop                     d_uop,
  output logic                      w_val,
  input  logic                      w_rdy,
  output logic [p_addr_bits-1:0]    w_pc,
  output logic [p_seq_num_bits-1:0] w_seq_num,
  output logic [4:0]                w_waddr,
  output logic [p_data_bits-1:0]    w_wdata,
  output logic                      w_wen,
  output logic [8*TRACE_CHARS-1:0]  trace
);
  localparam int N  = p_data_bits;
  localparam int B  = p_bits_per_cycle;
  localparam int K  = N / B;
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  mul_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2*N-1:0]            acc_q, acc_d, step_acc;
  logic [N-1:0]              mcand_q, mcand_d;
  logic [N-1:0]              mplier_q, mplier_d;
  logic                      neg_q, neg_d;
  logic                      take_high_q, take_high_d;
  logic [p_addr_bits-1:0]    pc_q, pc_d;
  logic [p_seq_num_bits-1:0] seq_q, seq_d;
  logic [4:0]                waddr_q, waddr_d;
  mul_ctrl_t                 ctrl_in;
  logic                      sign1, sign2;
  logic [7:0]                cnt8, seq8, st_ch;

  mul_step #(.N(N), .B(B), .CW(CW)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .slice_i (mplier_q[B-1:0]),
    .cnt_i   (cnt_q),
    .acc_o   (step_acc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    take_high_d = take_high_q;
    pc_d        = pc_q;
    seq_d       = seq_q;
    waddr_d     = waddr_q;
    ctrl_in     = mul_ctrl(d_uop);
    sign1       = ctrl_in.op1_signed & d_op1[N-1];
    sign2       = ctrl_in.op2_signed & d_op2[N-1];

    case (state_q)
      ST_IDLE: begin
        if (d_val) begin
          pc_d        = d_pc;
          seq_d       = d_seq_num;
          waddr_d     = d_waddr;
          take_high_d = ctrl_in.take_high;
          // -(most negative) wraps to 2^(N-1), which is the correct magnitude unsigned
          mcand_d     = sign1 ? -d_op1 : d_op1;
          mplier_d    = sign2 ? -d_op2 : d_op2;
          neg_d       = sign1 ^ sign2;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = step_acc;
        mplier_d = mplier_q >> B;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          if (neg_q) acc_d = -step_acc;
        end
      end
      ST_DONE: begin
        if (w_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      take_high_q <= 1'b0;
      pc_q        <= '0;
      seq_q       <= '0;
      waddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      take_high_q <= take_high_d;
      pc_q        <= pc_d;
      seq_q       <= seq_d;
      waddr_q     <= waddr_d;
    end
  end

  always_comb begin
    d_rdy     = (state_q == ST_IDLE);
    w_val     = (state_q == ST_DONE);
    w_wen     = (state_q == ST_DONE);
    w_pc      = pc_q;
    w_seq_num = seq_q;
    w_waddr   = waddr_q;
    w_wdata   = take_high_q ? acc_q[2*N-1:N] : acc_q[N-1:0];
  end

  // Trace format "S cc ss": state letter, iteration counter, seq_num (hex).
  always_comb begin
    cnt8 = 8'(cnt_q);
    seq8 = 8'(seq_q);
    case (state_q)
      ST_IDLE: st_ch = "I";
      ST_CALC: st_ch = "C";
      ST_DONE: st_ch = "D";
      default: st_ch = "?";
    endcase
    trace = {st_ch, 8'h20, hex_char(cnt8[7:4]), hex_char(cnt8[3:0]),
             8'h20, hex_char(seq8[7:4]), hex_char(seq8[3:0])};
  end

endmodule

// File: tb/tb_iter_mul_unit.sv
// Bench for iter_mul_unit: three instances (B=1,4,8), table vectors, random ops
// against a full-width product model, backpressure and mid-operation reset.
module tb_iter_mul_unit;
  import iter_mul_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_val   [3];
  logic        d_rdy   [3];
  logic [31:0] d_pc    [3];
  logic [4:0]  d_seq   [3];
  logic [31:0] d_op1   [3];
  logic [31:0] d_op2   [3];
  logic [4:0]  d_waddr [3];
  rv_uop       d_uop   [3];
  logic        w_val   [3];
  logic        w_rdy   [3];
  logic [31:0] w_pc    [3];
  logic [4:0]  w_seq   [3];
  logic [4:0]  w_waddr [3];
  logic [31:0] w_wdata [3];
  logic        w_wen   [3];
  logic [55:0] trace   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    iter_mul_unit #(
      .p_addr_bits(32), .p_data_bits(32), .p_seq_num_bits(5), .p_bits_per_cycle(BPC)
    ) u_dut (
      .clk(clk), .rst(rst_n),
      .d_val(d_val[g]), .d_rdy(d_rdy[g]), .d_pc(d_pc[g]), .d_seq_num(d_seq[g]),
      .d_op1(d_op1[g]), .d_op2(d_op2[g]), .d_waddr(d_waddr[g]), .d_uop(d_uop[g]),
      .w_val(w_val[g]), .w_rdy(w_rdy[g]), .w_pc(w_pc[g]), .w_seq_num(w_seq[g]),
      .w_waddr(w_waddr[g]), .w_wdata(w_wdata[g]), .w_wen(w_wen[g]), .trace(trace[g])
    );
  end

  typedef struct {
    rv_uop       uop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t  tbl [11];
  rv_uop ops [4];

  function automatic int kof(input int u);
    return (u == 0) ? 32 : ((u == 1) ? 8 : 4);
  endfunction

  // Reference: exact product of sign/zero-extended operands, then pick a half.
  function automatic logic [31:0] ref_mul(input rv_uop uop, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] ea, eb, p;
    bit sa, sb;
    sa = (uop == OP_MULH) || (uop == OP_MULHSU);
    sb = (uop == OP_MULH);
    ea = sa ? {{34{a[31]}}, a} : {34'd0, a};
    eb = sb ? {{34{b[31]}}, b} : {34'd0, b};
    p  = ea * eb;
    return (uop == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_val();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input int u, input logic [31:0] pc, input logic [4:0] seq,
                        input logic [4:0] wa, input rv_uop uop, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int dly_in, input int dly_out, input string nm);
    int n;
    repeat (dly_in) @(negedge clk);
    @(negedge clk);
    d_val[u] = 1'b1; d_pc[u] = pc; d_seq[u] = seq; d_waddr[u] = wa;
    d_uop[u] = uop; d_op1[u] = a; d_op2[u] = b;
    n = 0;
    while (!d_rdy[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!d_rdy[u]) begin
      chk($sformatf("%s d_rdy timeout", nm), d_rdy[u], 1);
      d_val[u] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    d_val[u] = 1'b0;
    d_pc[u] = $urandom; d_op1[u] = $urandom; d_op2[u] = $urandom;
    d_seq[u] = 5'($urandom); d_waddr[u] = 5'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!w_val[u] && n < 200);
    chk($sformatf("%s latency", nm), n, kof(u) + 1);
    if (!w_val[u]) begin
      chk($sformatf("%s w_val timeout", nm), w_val[u], 1);
      return;
    end
    for (int i = 0; i < dly_out; i++) begin
      chk($sformatf("%s hold wdata", nm), w_wdata[u], exp);
      chk($sformatf("%s hold w_val", nm), w_val[u], 1);
      chk($sformatf("%s hold d_rdy", nm), d_rdy[u], 0);
      @(negedge clk);
    end
    chk($sformatf("%s wdata", nm), w_wdata[u], exp);
    chk($sformatf("%s wen", nm), w_wen[u], 1);
    chk($sformatf("%s pc", nm), w_pc[u], pc);
    chk($sformatf("%s seq", nm), w_seq[u], seq);
    chk($sformatf("%s waddr", nm), w_waddr[u], wa);
    chk($sformatf("%s d_rdy busy", nm), d_rdy[u], 0);
    w_rdy[u] = 1'b1;
    @(posedge clk);
    #1;
    w_rdy[u] = 1'b0;
    @(negedge clk);
    chk($sformatf("%s w_val drop", nm), w_val[u], 0);
    chk($sformatf("%s d_rdy back", nm), d_rdy[u], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    int di, dd;
    rv_uop op;
    logic [31:0] a, b;

    tbl[0]  = '{OP_MUL,    32'd3,          32'd4,          32'd12};
    tbl[1]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    tbl[2]  = '{OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    tbl[3]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
    tbl[4]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    tbl[5]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    tbl[6]  = '{OP_MULHSU, 32'd2,          32'h8000_0000,  32'h0000_0001};
    tbl[7]  = '{OP_MUL,    32'd0,          32'd12345,      32'd0};
    tbl[8]  = '{OP_MULH,   32'h8000_0000,  32'd1,          32'hFFFF_FFFF};
    tbl[9]  = '{OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    tbl[10] = '{OP_MUL,    32'h8000_0000,  32'h8000_0000,  32'h0000_0000};
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};

    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      d_val[u] = 1'b0; w_rdy[u] = 1'b0; d_pc[u] = '0; d_seq[u] = '0;
      d_op1[u] = '0; d_op2[u] = '0; d_waddr[u] = '0; d_uop[u] = OP_MUL;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset w_val u%0d", u), w_val[u], 0);
      chk($sformatf("reset w_wen u%0d", u), w_wen[u], 0);
      chk($sformatf("reset w_wdata u%0d", u), w_wdata[u], 0);
      chk($sformatf("reset w_pc u%0d", u), w_pc[u], 0);
      chk($sformatf("reset w_seq u%0d", u), w_seq[u], 0);
      chk($sformatf("reset w_waddr u%0d", u), w_waddr[u], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("post-reset d_rdy u%0d", u), d_rdy[u], 1);
      chk($sformatf("post-reset trace state u%0d", u), trace[u][55:48], 8'h49);
    end

    // Table vectors: all delay suites on B=1, latency sweep on B=4 and B=8.
    for (int s = 0; s < 4; s++) begin
      di = (s == 1 || s == 3) ? 3 : 0;
      dd = (s == 2 || s == 3) ? 3 : 0;
      for (int i = 0; i < 11; i++)
        run_op(0, 32'h100 * i, 5'(i), 5'(i + 1), tbl[i].uop, tbl[i].a, tbl[i].b,
               tbl[i].exp, di, dd, $sformatf("tbl s%0d v%0d", s, i));
    end
    for (int u = 1; u < 3; u++)
      for (int i = 0; i < 11; i++)
        run_op(u, 32'h200 + i, 5'(i), 5'(i + 2), tbl[i].uop, tbl[i].a, tbl[i].b,
               tbl[i].exp, 0, 0, $sformatf("tbl u%0d v%0d", u, i));

    for (int i = 1; i <= 5; i++)
      run_op(0, 32'h4000 + 4 * i, 5'(i), 5'(i), OP_MUL, 32'(i), 32'd10, 32'(10 * i),
             0, 0, $sformatf("b2b seq%0d", i));

    run_op(0, 32'h5000, 5'd9, 5'd3, OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678,
           ref_mul(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678), 0, 5, "bp5");

    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 20; i++) begin
        op = ops[$urandom_range(0, 3)];
        a  = pick_val();
        b  = pick_val();
        run_op(u, $urandom, 5'($urandom), 5'($urandom), op, a, b, ref_mul(op, a, b),
               $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd u%0d n%0d", u, i));
      end

    // Reset during the third CALC cycle must drop the operation entirely.
    @(negedge clk);
    d_val[0] = 1'b1; d_pc[0] = 32'hABC; d_seq[0] = 5'd7; d_waddr[0] = 5'd4;
    d_uop[0] = OP_MUL; d_op1[0] = 32'd9; d_op2[0] = 32'd9;
    @(posedge clk);
    #1;
    d_val[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset trace calc", trace[0][55:48], 8'h43);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset w_val", w_val[0], 0);
    chk("midreset trace idle", trace[0][55:48], 8'h49);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset d_rdy", d_rdy[0], 1);
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (w_val[0]) stale++;
    end
    chk("midreset no stale", stale, 0);
    run_op(0, 32'h6000, 5'd11, 5'd5, OP_MUL, 32'd5, 32'd7, 32'd35, 0, 0, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
